// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for the systolic_pe array: accepts activation columns, skews lane r by r+1
// cycles onto the west edge, and sequences clear/compute/flush/done for one tile.
module systolic_skew_feeder #(
    parameter int DATA_BITS = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_MAX     = 255,
    localparam int KW       = $clog2(K_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*DATA_BITS-1:0] in_data,
    output logic [ROWS*DATA_BITS-1:0] a_skew,
    output logic                      array_enable,
    output logic                      clear_acc,
    output logic                      compute_enable,
    output logic                      done
);

    localparam int DW = $clog2(ROWS + COLS);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ROWS + COLS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] kreg;
    logic [KW-1:0] kcnt;
    logic [DW-1:0] dcnt;

    logic fire;
    logic draining;
    logic shift;

    assign draining = (state == S_DRAIN);
    assign in_ready = enable & (state == S_STREAM);
    assign fire     = in_valid & in_ready;
    assign shift    = fire | (enable & draining);

    assign busy         = (state != S_IDLE);
    assign clear_acc    = enable & (state == S_CLEAR);
    assign done         = enable & (state == S_DONE);
    assign array_enable = enable & ((state == S_CLEAR) | fire | draining);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            kreg           <= '0;
            kcnt           <= '0;
            dcnt           <= '0;
            compute_enable <= '0;
        end else if (enable) begin
            // One cycle behind the shift so it lines up with the data now on a_skew
            compute_enable <= fire | draining;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        kreg  <= k_len;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    kcnt  <= '0;
                    dcnt  <= '0;
                    state <= (kreg == '0) ? S_DONE : S_STREAM;
                end
                S_STREAM: begin
                    if (fire) begin
                        kcnt <= kcnt + KW'(1);
                        if (kcnt == kreg - KW'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (dcnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_BITS-1:0] stg [r+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned i = 0; i <= r; i++) begin
                    stg[i] <= '0;
                end
            end else if (shift) begin
                stg[0] <= draining ? '0 : in_data[r*DATA_BITS +: DATA_BITS];
                for (int unsigned i = 1; i <= r; i++) begin
                    stg[i] <= stg[i-1];
                end
            end
        end

        assign a_skew[r*DATA_BITS +: DATA_BITS] = stg[r];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-cycle expectations for reset, plain tile,
// bubbles, empty tile, ignored start, mid-tile reset and an enable freeze during drain.
module tb_systolic_skew_feeder;

    localparam int DATA_BITS = 16;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int K_MAX     = 255;
    localparam int KW        = 8;
    localparam int W         = ROWS * DATA_BITS;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  a_skew;
    logic          array_enable;
    logic          clear_acc;
    logic          compute_enable;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    systolic_skew_feeder #(
        .DATA_BITS (DATA_BITS),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .K_MAX     (K_MAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .start          (start),
        .k_len          (k_len),
        .busy           (busy),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .a_skew         (a_skew),
        .array_enable   (array_enable),
        .clear_acc      (clear_acc),
        .compute_enable (compute_enable),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Column j: lane r holds 0x1000*(j+1) + r
    function automatic logic [W-1:0] col(input int j);
        logic [W-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            v[r*DATA_BITS +: DATA_BITS] = DATA_BITS'(16'h1000 * (j + 1) + r);
        end
        return v;
    endfunction

    // Expected west edge after n advancing cycles, the first k of which carried columns 0..k-1
    function automatic logic [W-1:0] skew_exp(input int n, input int k);
        logic [W-1:0] v;
        logic [W-1:0] c;
        int j;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            j = n - 1 - r;
            if (j >= 0 && j < k) begin
                c = col(j);
                v[r*DATA_BITS +: DATA_BITS] = c[r*DATA_BITS +: DATA_BITS];
            end
        end
        return v;
    endfunction

    function automatic int clampz(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle(input string t, input int c, input int n, input int k,
                             input bit e_busy, input bit e_rdy, input bit e_ae,
                             input bit e_clr, input bit e_ce, input bit e_done);
        check($sformatf("%s c%0d busy", t, c),           W'(busy),           W'(e_busy));
        check($sformatf("%s c%0d in_ready", t, c),       W'(in_ready),       W'(e_rdy));
        check($sformatf("%s c%0d array_enable", t, c),   W'(array_enable),   W'(e_ae));
        check($sformatf("%s c%0d clear_acc", t, c),      W'(clear_acc),      W'(e_clr));
        check($sformatf("%s c%0d compute_enable", t, c), W'(compute_enable), W'(e_ce));
        check($sformatf("%s c%0d done", t, c),           W'(done),           W'(e_done));
        check($sformatf("%s c%0d a_skew", t, c),         a_skew,             skew_exp(n, k));
    endtask

    initial begin
        // T1: reset held two cycles with in_valid high
        reset    = 1'b1;
        enable   = 1'b1;
        start    = 1'b0;
        in_valid = 1'b1;
        k_len    = '0;
        in_data  = col(0);
        cyc();
        cyc();
        #1;
        chk_cycle("t1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        cyc();

        // T2: k_len=3, no stalls
        for (int c = 0; c <= 13; c++) begin
            start    = (c == 0);
            k_len    = 8'd3;
            in_valid = (c >= 1 && c <= 4);
            in_data  = col(clampz(c - 2));
            #1;
            chk_cycle("t2", c, clampz(c - 2), 3, c >= 1 && c <= 12, c >= 2 && c <= 4,
                      c >= 1 && c <= 11, c == 1, c >= 3 && c <= 12, c == 12);
            cyc();
        end

        // T3: two bubble cycles between C1 and C2
        for (int c = 0; c <= 15; c++) begin
            int n;
            start    = (c == 0);
            k_len    = 8'd3;
            in_valid = (c >= 1 && c <= 3) || (c == 6);
            in_data  = (c == 6) ? col(2) : col(clampz(c - 2));
            n = (c <= 2) ? 0 : (c <= 4) ? c - 2 : (c <= 6) ? 2 : c - 4;
            #1;
            chk_cycle("t3", c, n, 3, c >= 1 && c <= 14, c >= 2 && c <= 6,
                      (c >= 1 && c <= 3) || (c >= 6 && c <= 13), c == 1,
                      (c >= 3 && c <= 4) || (c >= 7 && c <= 14), c == 14);
            cyc();
        end

        // T4: empty tile
        for (int c = 0; c <= 3; c++) begin
            start    = (c == 0);
            k_len    = 8'd0;
            in_valid = 1'b1;
            in_data  = col(0);
            #1;
            chk_cycle("t4", c, 0, 0, c >= 1 && c <= 2, 0, c == 1, c == 1, 0, c == 2);
            cyc();
        end

        // T5: start during STREAM ignored; back-to-back tile right after done
        for (int c = 0; c <= 23; c++) begin
            start    = (c == 0) || (c == 2) || (c == 12);
            k_len    = (c == 0) ? 8'd2 : (c == 12) ? 8'd1 : 8'd5;
            in_valid = (c == 2) || (c == 3) || (c == 14);
            in_data  = (c <= 3) ? col(clampz(c - 2)) : col(0);
            #1;
            if (c <= 12) begin
                chk_cycle("t5", c, clampz(c - 2), 2, c >= 1 && c <= 11, c >= 2 && c <= 3,
                          c >= 1 && c <= 10, c == 1, c >= 3 && c <= 11, c == 11);
            end else begin
                chk_cycle("t5", c, clampz(c - 14), 1, c <= 22, c == 14,
                          c <= 21, c == 13, c >= 15 && c <= 22, c == 22);
            end
            cyc();
        end

        // T6: reset after two of five columns, then a clean tile
        for (int c = 0; c <= 8; c++) begin
            start    = (c == 0);
            k_len    = 8'd5;
            reset    = (c == 4);
            in_valid = (c >= 1 && c <= 3);
            in_data  = col(clampz(c - 2));
            #1;
            if (c != 4) begin
                chk_cycle("t6a", c, (c <= 4) ? clampz(c - 2) : 0, 5, c >= 1 && c <= 3,
                          c >= 2 && c <= 3, c >= 1 && c <= 3, c == 1, c == 3, 0);
            end
            cyc();
        end
        for (int c = 0; c <= 11; c++) begin
            start    = (c == 0);
            k_len    = 8'd1;
            in_valid = (c == 2);
            in_data  = col(0);
            #1;
            chk_cycle("t6b", c, clampz(c - 2), 1, c >= 1 && c <= 10, c == 2,
                      c >= 1 && c <= 9, c == 1, c >= 3 && c <= 10, c == 10);
            cyc();
        end

        // T7: enable low for three cycles mid-drain
        for (int c = 0; c <= 14; c++) begin
            int n;
            start    = (c == 0);
            k_len    = 8'd1;
            enable   = !(c >= 5 && c <= 7);
            in_valid = (c == 2);
            in_data  = col(0);
            n = (c <= 2) ? 0 : (c <= 5) ? c - 2 : (c <= 8) ? 3 : c - 5;
            #1;
            chk_cycle("t7", c, n, 1, c >= 1 && c <= 13, c == 2,
                      (c >= 1 && c <= 4) || (c >= 8 && c <= 12), c == 1,
                      c >= 3 && c <= 13, c == 13);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
